// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse-cipher datapath.
//   AES_STATE_W / AES_COL_W : state and column widths
//   INV_MC_*                : InvMixColumns matrix coefficients
//   gf_xtime                : multiply by x in GF(2^8) mod 0x11B
//   gf_mul_const            : multiply by a small constant via an xtime chain
//   inv_mc_state_e          : sequencer states for inv_mix_columns_seq
package aes_pkg;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_COL_W   = 32;

    localparam logic [7:0] INV_MC_0E = 8'h0e;
    localparam logic [7:0] INV_MC_0B = 8'h0b;
    localparam logic [7:0] INV_MC_0D = 8'h0d;
    localparam logic [7:0] INV_MC_09 = 8'h09;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } inv_mc_state_e;

    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Only the low nibble of k is honoured; every InvMixColumns coefficient
    // fits in four bits, so the product is x, x*2, x*4, x*8 XORed together.
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b,
                                                input logic [7:0] k);
        logic [7:0] acc;
        logic [7:0] pw;
        logic [7:0] kk;
        acc = '0;
        pw  = b;
        kk  = k;
        for (int unsigned i = 0; i < 4; i++) begin
            if (kk[0]) begin
                acc = acc ^ pw;
            end
            pw = gf_xtime(pw);
            kk = kk >> 1;
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns for one 32-bit AES column.
//   col_in  : column, row 0 in bits [31:24], row 3 in bits [7:0]
//   col_out : transformed column, same byte layout
module inv_mix_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] r0, r1, r2, r3;

    assign {r0, r1, r2, r3} = col_in;

    assign col_out[31:24] = gf_mul_const(r0, INV_MC_0E) ^ gf_mul_const(r1, INV_MC_0B)
                          ^ gf_mul_const(r2, INV_MC_0D) ^ gf_mul_const(r3, INV_MC_09);
    assign col_out[23:16] = gf_mul_const(r0, INV_MC_09) ^ gf_mul_const(r1, INV_MC_0E)
                          ^ gf_mul_const(r2, INV_MC_0B) ^ gf_mul_const(r3, INV_MC_0D);
    assign col_out[15:8]  = gf_mul_const(r0, INV_MC_0D) ^ gf_mul_const(r1, INV_MC_09)
                          ^ gf_mul_const(r2, INV_MC_0E) ^ gf_mul_const(r3, INV_MC_0B);
    assign col_out[7:0]   = gf_mul_const(r0, INV_MC_0B) ^ gf_mul_const(r1, INV_MC_0D)
                          ^ gf_mul_const(r2, INV_MC_09) ^ gf_mul_const(r3, INV_MC_0E);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns engine, COLS_PER_CYCLE columns per clock.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake, in_state captured on in_valid & in_ready
//   in_state            : 128-bit state, column c in bits [32c+31:32c]
//   out_valid/out_ready : output handshake, out_state held until accepted
//   out_state           : transformed state
module inv_mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned NCYC     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LAST_CNT = 2'(NCYC - 1);

    inv_mc_state_e          state_q, state_d;
    logic [AES_STATE_W-1:0] src_q, src_d;
    logic [AES_STATE_W-1:0] res_q, res_d;
    logic [1:0]             col_cnt_q, col_cnt_d;

    logic [1:0]             col_base;
    logic [AES_STATE_W-1:0] res_busy;
    logic [AES_COL_W-1:0]   grp_in  [COLS_PER_CYCLE];
    logic [AES_COL_W-1:0]   grp_out [COLS_PER_CYCLE];

    // First column of the current group: col_cnt * COLS_PER_CYCLE, and for
    // the legal values 1/2/4 the shift amount log2(COLS_PER_CYCLE) is CPC/2.
    assign col_base = col_cnt_q << (COLS_PER_CYCLE / 2);

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_grp
        logic [1:0] col_idx;
        assign col_idx   = col_base + 2'(g);
        assign grp_in[g] = src_q[{col_idx, 5'b0} +: AES_COL_W];

        inv_mix_column u_col (
            .col_in  (grp_in[g]),
            .col_out (grp_out[g])
        );
    end

    // Column c is produced by group lane c % CPC during count c / CPC; all
    // other columns keep their previous result this cycle.
    for (genvar c = 0; c < 4; c++) begin : g_res
        assign res_busy[c*AES_COL_W +: AES_COL_W] =
            (col_cnt_q == 2'(c / COLS_PER_CYCLE)) ? grp_out[c % COLS_PER_CYCLE]
                                                  : res_q[c*AES_COL_W +: AES_COL_W];
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        res_d     = res_q;
        col_cnt_d = col_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    src_d     = in_state;
                    col_cnt_d = '0;
                    state_d   = ST_BUSY;
                end
            end

            ST_BUSY: begin
                res_d = res_busy;
                if (col_cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end else begin
                    col_cnt_d = col_cnt_q + 2'd1;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        src_d     = in_state;
                        col_cnt_d = '0;
                        state_d   = ST_BUSY;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            res_q     <= '0;
            col_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            res_q     <= res_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    assign out_state = res_q;

endmodule
